// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared FIR constants and sequencer state encoding.
// Revision : 1.0  initial release
// ============================================================================
package fir_pkg;

    localparam int FIR_DATA_WIDTH = 16;
    localparam int FIR_TAPS       = 128;
    localparam int FIR_ACC_WIDTH  = 40;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_OUTPUT = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_tap_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_sequencer_if
// Purpose  : Sample handshake, BRAM address/data and result bundle.
// Revision : 1.0  initial release
// ============================================================================
interface fir_tap_sequencer_if
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(FIR_TAPS)
) ();

    logic                         i_sample_valid;
    logic signed [DATA_WIDTH-1:0] i_sample;
    logic                         o_sample_ready;
    logic                         o_we_en;
    logic        [ADDR_WIDTH-1:0] o_addr_wr;
    logic signed [DATA_WIDTH-1:0] o_data_wr;
    logic        [ADDR_WIDTH-1:0] o_addr_rd;
    logic        [ADDR_WIDTH-1:0] o_coef_addr;
    logic signed [DATA_WIDTH-1:0] i_sample_rd;
    logic signed [DATA_WIDTH-1:0] i_coef_rd;
    logic signed [DATA_WIDTH-1:0] o_result;
    logic                         o_result_valid;
    logic                         o_busy;

    modport master (
        input  i_sample_valid, i_sample, i_sample_rd, i_coef_rd,
        output o_sample_ready, o_we_en, o_addr_wr, o_data_wr, o_addr_rd,
               o_coef_addr, o_result, o_result_valid, o_busy
    );

    modport slave (
        output i_sample_valid, i_sample, i_sample_rd, i_coef_rd,
        input  o_sample_ready, o_we_en, o_addr_wr, o_data_wr, o_addr_rd,
               o_coef_addr, o_result, o_result_valid, o_busy
    );

endinterface
`default_nettype wire

// File: rtl/fir_mac.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac
// Purpose  : Signed multiply-accumulate with synchronous clear.
// Revision : 1.0  initial release
// ============================================================================
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int ACC_WIDTH  = FIR_ACC_WIDTH
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         i_clear,
    input  wire logic                         i_enable,
    input  wire logic signed [DATA_WIDTH-1:0] i_a,
    input  wire logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed      [ACC_WIDTH-1:0]  o_acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc_d;
    logic signed [ACC_WIDTH-1:0]    acc_q;

    always_comb begin
        prod     = i_a * i_b;
        prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
        acc_d    = acc_q;
        if (i_clear) begin
            acc_d = '0;
        end else if (i_enable) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_sequencer
// Purpose  : Circular-buffer FIR controller driving one shared MAC.
// Revision : 1.0  initial release
// ============================================================================
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int TAPS       = FIR_TAPS,
    parameter int ADDR_WIDTH = $clog2(TAPS),
    parameter int ACC_WIDTH  = FIR_ACC_WIDTH
) (
    input wire logic            clk,
    input wire logic            i_rstn,
    fir_tap_sequencer_if.master bus
);

    localparam logic [ADDR_WIDTH:0]   CNT_TAPS = (ADDR_WIDTH+1)'(TAPS);
    localparam logic [ADDR_WIDTH-1:0] K_LAST   = ADDR_WIDTH'(TAPS-1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    state_t                       state_q, state_d;
    logic        [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic        [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                         sample_ready_q, sample_ready_d;
    logic                         we_en_q, we_en_d;
    logic        [ADDR_WIDTH-1:0] addr_wr_q, addr_wr_d;
    logic signed [DATA_WIDTH-1:0] data_wr_q, data_wr_d;
    logic        [ADDR_WIDTH-1:0] addr_rd_q, addr_rd_d;
    logic        [ADDR_WIDTH-1:0] coef_addr_q, coef_addr_d;
    logic signed [DATA_WIDTH-1:0] result_q, result_d;
    logic                         result_valid_q, result_valid_d;
    logic                         busy_q, busy_d;

    logic                         mac_clear;
    logic                         mac_en;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_shift;
    logic signed [DATA_WIDTH-1:0] result_sat;
    logic        [ADDR_WIDTH-1:0] k;
    logic        [ADDR_WIDTH-1:0] k_next;

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst_n    (i_rstn),
        .i_clear  (mac_clear),
        .i_enable (mac_en),
        .i_a      (bus.i_sample_rd),
        .i_b      (bus.i_coef_rd),
        .o_acc    (acc)
    );

    always_comb begin
        acc_shift = acc >>> (DATA_WIDTH-1);
        if (acc_shift > SAT_MAX) begin
            result_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc_shift < SAT_MIN) begin
            result_sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            result_sat = acc_shift[DATA_WIDTH-1:0];
        end
    end

    assign k      = cnt_q[ADDR_WIDTH-1:0];
    assign k_next = k + ADDR_WIDTH'(1);

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wr_ptr_d       = wr_ptr_q;
        sample_ready_d = 1'b0;
        we_en_d        = 1'b0;
        addr_wr_d      = addr_wr_q;
        data_wr_d      = data_wr_q;
        addr_rd_d      = addr_rd_q;
        coef_addr_d    = coef_addr_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        mac_clear      = 1'b0;
        mac_en         = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CNT_TAPS) begin
                    state_d        = ST_IDLE;
                    sample_ready_d = 1'b1;
                end else begin
                    we_en_d   = 1'b1;
                    addr_wr_d = cnt_q[ADDR_WIDTH-1:0];
                    data_wr_d = '0;
                    cnt_d     = cnt_q + (ADDR_WIDTH+1)'(1);
                end
            end
            ST_IDLE: begin
                if (bus.i_sample_valid) begin
                    state_d   = ST_WRITE;
                    we_en_d   = 1'b1;
                    addr_wr_d = wr_ptr_q;
                    data_wr_d = bus.i_sample;
                end else begin
                    sample_ready_d = 1'b1;
                end
            end
            ST_WRITE: begin
                mac_clear   = 1'b1;
                cnt_d       = '0;
                addr_rd_d   = wr_ptr_q;
                coef_addr_d = '0;
                state_d     = ST_READ;
            end
            ST_READ: begin
                // Read data trails the address by one cycle, so tap 0 lands next cycle.
                mac_en = (k != '0);
                if (k == K_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d       = cnt_q + (ADDR_WIDTH+1)'(1);
                    addr_rd_d   = wr_ptr_q - k_next;
                    coef_addr_d = k_next;
                end
            end
            ST_DRAIN: begin
                mac_en   = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                state_d  = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                result_d       = result_sat;
                result_valid_d = 1'b1;
                sample_ready_d = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q        <= ST_CLEAR;
            cnt_q          <= '0;
            wr_ptr_q       <= '0;
            sample_ready_q <= 1'b0;
            we_en_q        <= 1'b0;
            addr_wr_q      <= '0;
            data_wr_q      <= '0;
            addr_rd_q      <= '0;
            coef_addr_q    <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            sample_ready_q <= sample_ready_d;
            we_en_q        <= we_en_d;
            addr_wr_q      <= addr_wr_d;
            data_wr_q      <= data_wr_d;
            addr_rd_q      <= addr_rd_d;
            coef_addr_q    <= coef_addr_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.o_sample_ready = sample_ready_q;
    assign bus.o_we_en        = we_en_q;
    assign bus.o_addr_wr      = addr_wr_q;
    assign bus.o_data_wr      = data_wr_q;
    assign bus.o_addr_rd      = addr_rd_q;
    assign bus.o_coef_addr    = coef_addr_q;
    assign bus.o_result       = result_q;
    assign bus.o_result_valid = result_valid_q;
    assign bus.o_busy         = busy_q;

endmodule
`default_nettype wire

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Controller for the multiplexed FIR datapath. It keeps the sample delay line as a circular buffer in the dual-port sample BRAM and walks all taps through one multiply-accumulate. For each input sample it steps the sample-read and coefficient-read addresses in lockstep, then emits one saturated output. It sits between the sample source and the two BRAMs (sample, coefficient), and owns all their address/write-enable lines.

## Interface
Parameters:
- DATA_WIDTH, 16, signed sample/coefficient/result width (Q1.15).
- TAPS, 128, filter length; must be a power of two.
- ADDR_WIDTH, $clog2(TAPS), BRAM address width.
- ACC_WIDTH, 40, accumulator width; must be >= 2*DATA_WIDTH + ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_sample_valid  in  1  input sample offered.
- i_sample  in  DATA_WIDTH  signed input sample.
- o_sample_ready  out  1  sequencer accepts a sample this cycle.
- o_we_en  out  1  sample BRAM write enable.
- o_addr_wr  out  ADDR_WIDTH  sample BRAM write address.
- o_data_wr  out  DATA_WIDTH  sample BRAM write data.
- o_addr_rd  out  ADDR_WIDTH  sample BRAM read address.
- o_coef_addr  out  ADDR_WIDTH  coefficient BRAM read address.
- i_sample_rd  in  DATA_WIDTH  sample BRAM read data; 1-cycle read latency.
- i_coef_rd  in  DATA_WIDTH  coefficient BRAM read data; 1-cycle read latency.
- o_result  out  DATA_WIDTH  filtered output; held until the next result.
- o_result_valid  out  1  one-cycle pulse when o_result updates.
- o_busy  out  1  high in every state except IDLE.

## Operation
- States: CLEAR, IDLE, WRITE, READ, DRAIN, OUTPUT.
- Reset: every output is 0; state goes to CLEAR; wr_ptr, tap counter and accumulator are 0.
- CLEAR: write 0 to addresses 0..TAPS-1, one per cycle (o_we_en=1, o_data_wr=0), then go to IDLE. BRAM contents are undefined after power-up, so this pass is mandatory.
- IDLE: o_sample_ready=1. When i_sample_valid is high, register i_sample and go to WRITE. While ready is 0, i_sample_valid is ignored; the source holds the sample.
- WRITE: o_we_en=1, o_addr_wr=wr_ptr, o_data_wr=the registered sample. Clear the accumulator and set k=0.
- READ: lasts TAPS cycles, k=0..TAPS-1.
  - o_addr_rd=(wr_ptr-k) mod TAPS, so the newest sample is read first; wrap is natural ADDR_WIDTH overflow.
  - o_coef_addr=k.
  - From the second READ cycle on, accumulate the product of the previous cycle's read data.
- DRAIN: accumulate the last product, then advance wr_ptr by 1 (wraps TAPS-1 to 0).
- OUTPUT: o_result = saturate(acc >>> (DATA_WIDTH-1)), clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. o_result_valid is asserted the following cycle; the state returns to IDLE.
- Arithmetic: signed DATA_WIDTH×DATA_WIDTH product, sign-extended to ACC_WIDTH. The accumulator cannot overflow given the ACC_WIDTH constraint.
- Read-during-write never happens on one address: the first read of wr_ptr comes one cycle after its write.
- Reset asserted mid-operation: the current computation is abandoned and no result is produced. CLEAR reruns, so the history is zeroed.

## Timing
- Sample accepted in cycle T (valid and ready both high):
  - WRITE in T+1.
  - READ in T+2..T+TAPS+1.
  - DRAIN in T+TAPS+2.
  - OUTPUT in T+TAPS+3.
  - o_result_valid and o_sample_ready both high in T+TAPS+4.
- Throughput: one sample per TAPS+4 cycles (132 for the defaults).
- CLEAR lasts TAPS cycles after reset release; o_sample_ready first rises in cycle TAPS.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package/include fir_pkg: state encodings, and the default DATA_WIDTH/TAPS/ACC_WIDTH constants used by the BRAMs and this block.
- One sub-module, fir_mac:
  - Inputs: clear, enable and two operands.
  - Holds the accumulator register and does the product sign-extension.
  - Saturation stays in the sequencer.

## Test plan
- Reset release: 128 consecutive writes with o_we_en=1, o_addr_wr=0..127, data 0. o_sample_ready rises in cycle 128 and o_result_valid stays 0.
- Impulse: coefficients h[k]=k, one sample 0x7FFF, then zeros. The n-th result equals (0x7FFF*n)>>>15 = n-1 for n>=1 (first result 0), and o_result_valid spacing is 132 cycles.
- Wrap: 130 samples. o_addr_wr goes 0..127, 0, 1; in the READ phase after the sample written to address 1, o_addr_rd runs 1, 0, 127, 126...
- Saturation: all coefficients 0x7FFF with 128 samples of 0x7FFF gives 0x7FFF. Samples of 0x8000 with coefficients 0x7FFF give 0x8000.
- Backpressure: i_sample_valid held high continuously. Exactly one acceptance per 132 cycles, and i_sample changes made while ready=0 are never written.
- Mid-READ reset: assert i_rstn low at READ k=50. All outputs go to 0 immediately, no o_result_valid follows, CLEAR reruns, and the next impulse response matches a fresh start.
